// File: rtl/seg_scan_ctrl_if.sv
// Bundle for seg_scan_ctrl: number sources in, display pins, status and debug taps out.
// The debug taps expose FSM state, side select and both BCD banks for checkers.
interface seg_scan_ctrl_if;
  logic [7:0] num_left;
  logic [7:0] num_right;
  logic [7:0] DIG;
  logic [7:0] Y;
  logic       busy;
  logic       upd;
  logic [1:0] dbg_state;
  logic       dbg_sel;
  logic [9:0] dbg_bank_left;
  logic [9:0] dbg_bank_right;

  modport master (
    output num_left, num_right,
    input  DIG, Y, busy, upd, dbg_state, dbg_sel, dbg_bank_left, dbg_bank_right
  );

  modport slave (
    input  num_left, num_right,
    output DIG, Y, busy, upd, dbg_state, dbg_sel, dbg_bank_left, dbg_bank_right
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 8-digit 7-segment scheduler: one shared shift-add-3 BCD converter alternating sides,
// per-side BCD banks, prescaled digit scan. Define SEG_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] TERM = DIV_W'(SCAN_DIV - 1);

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  state_t      state;
  logic        sel;
  logic [17:0] sr;
  logic [2:0]  sh_cnt;
  logic [9:0]  bank_left;
  logic [9:0]  bank_right;
  logic        busy_q;
  logic        upd_q;

  logic [DIV_W-1:0] pre_cnt;
  logic [2:0]       idx;
  logic [7:0]       dig_q;
  logic [7:0]       y_q;

  logic [9:0] cur_bank;
  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [7:0] seg_next;

  // One double-dabble step: correct both BCD nibbles that will overflow, then shift.
  function automatic logic [17:0] dabble_step(input logic [17:0] v);
    logic [17:0] t;
    t = v;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[16:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hC0;
    endcase
    return s;
  endfunction

  // Converter: IDLE -> LOAD -> SHIFT x8 -> STORE, alternating sides every pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      sr         <= '0;
      sh_cnt     <= '0;
      bank_left  <= '0;
      bank_right <= '0;
      busy_q     <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= LOAD;
          busy_q <= 1'b1;
        end
        LOAD: begin
          sr     <= {10'b0, (sel ? bus.num_left : bus.num_right)};
          sh_cnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          sr     <= dabble_step(sr);
          sh_cnt <= sh_cnt + 3'd1;
          if (sh_cnt == 3'd7) begin
            state <= STORE;
            upd_q <= 1'b1;
          end
        end
        STORE: begin
          if (sel) bank_left  <= sr[17:8];
          else     bank_right <= sr[17:8];
          sel    <= ~sel;
          upd_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank layout is {hun[1:0], ten[3:0], one[3:0]}; idx[2] picks the left side.
  always_comb begin
    cur_bank  = idx[2] ? bank_left : bank_right;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    case (idx[1:0])
      2'd0: cur_digit = cur_bank[3:0];
      2'd1: begin
        cur_digit = cur_bank[7:4];
        cur_blank = LZB && (cur_bank[9:8] == 2'd0) && (cur_bank[7:4] == 4'd0);
      end
      2'd2: begin
        cur_digit = {2'b00, cur_bank[9:8]};
        cur_blank = LZB && (cur_bank[9:8] == 2'd0);
      end
      default: cur_blank = 1'b1;
    endcase
    seg_next = cur_blank ? 8'hFF : seg_decode(cur_digit);
  end

  // DIG and Y are registered together from the same index, so only one digit is ever low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= '0;
      dig_q   <= 8'hFF;
      y_q     <= 8'hFF;
    end else begin
      if (pre_cnt == TERM) begin
        pre_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      dig_q <= ~(8'b1 << idx);
      y_q   <= seg_next;
    end
  end

  assign bus.DIG            = dig_q;
  assign bus.Y              = y_q;
  assign bus.busy           = busy_q;
  assign bus.upd            = upd_q;
  assign bus.dbg_state      = state;
  assign bus.dbg_sel        = sel;
  assign bus.dbg_bank_left  = bank_left;
  assign bus.dbg_bank_right = bank_right;

endmodule
